// File: rtl/heater_bank_sched_if.sv
// Configuration, temperature sample and status bundle between software/XADC logic and the heater sequencer.
// Status counter widths are parameters so reduced-width builds stay available; production uses the defaults.
interface heater_bank_sched_if #(
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned TEMP_BITS = 12,
  parameter int unsigned ON_BITS   = 32,
  parameter int unsigned TRIP_BITS = 16
);
  logic                 cfg_enable;
  logic [3:0]           cfg_banks;
  logic [PWM_BITS-1:0]  cfg_duty;
  logic [TEMP_BITS-1:0] cfg_temp_hi;
  logic [TEMP_BITS-1:0] cfg_temp_lo;
  logic [TEMP_BITS-1:0] temp_code;
  logic                 temp_valid;
  logic [NUM_BANKS-1:0] bank_en;
  logic [1:0]           state;
  logic [3:0]           active_count;
  logic [ON_BITS-1:0]   on_cycles;
  logic [TRIP_BITS-1:0] trip_count;

  modport master (
    output cfg_enable, cfg_banks, cfg_duty, cfg_temp_hi, cfg_temp_lo, temp_code, temp_valid,
    input  bank_en, state, active_count, on_cycles, trip_count
  );

  modport slave (
    input  cfg_enable, cfg_banks, cfg_duty, cfg_temp_hi, cfg_temp_lo, temp_code, temp_valid,
    output bank_en, state, active_count, on_cycles, trip_count
  );
endinterface

// File: rtl/heater_bank_sched.sv
// Ring-oscillator heater bank sequencer: soft-start ramp, PWM gating and
// over-temperature cutout with hysteresis, plus saturating status counters.
module heater_bank_sched #(
  parameter int unsigned NUM_BANKS   = 8,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned RAMP_CYCLES = 1024,
  parameter int unsigned TEMP_BITS   = 12,
  parameter int unsigned ON_BITS     = 32,
  parameter int unsigned TRIP_BITS   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  heater_bank_sched_if.slave bus
);

  localparam int unsigned TMR_BITS = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [TMR_BITS-1:0] TMR_LAST  = TMR_BITS'(RAMP_CYCLES - 1);
  localparam logic [3:0]          MAX_BANKS = 4'(NUM_BANKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2,
    ST_COOL = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           active_q, active_d;
  logic [TMR_BITS-1:0]  tmr_q, tmr_d;
  logic [TRIP_BITS-1:0] trip_q, trip_d;
  logic [ON_BITS-1:0]   on_q;
  logic [PWM_BITS-1:0]  pwm_q;
  logic [NUM_BANKS-1:0] bank_en_q, bank_en_d;

  logic [3:0] banks_c;
  logic       trip_c;
  logic       rearm_c;
  logic       pwm_on_c;

  assign banks_c  = (bus.cfg_banks > MAX_BANKS) ? MAX_BANKS : bus.cfg_banks;
  assign trip_c   = bus.temp_valid && (bus.temp_code >= bus.cfg_temp_hi);
  assign rearm_c  = bus.temp_valid && (bus.temp_code <= bus.cfg_temp_lo);
  assign pwm_on_c = (bus.cfg_duty == '1) || (pwm_q < bus.cfg_duty);

  // Next state; priority is run request drop, then over-temp trip, then ramp/track.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    tmr_d    = tmr_q;
    trip_d   = trip_q;
    if (!bus.cfg_enable) begin
      state_d  = ST_IDLE;
      active_d = '0;
      tmr_d    = '0;
    end else if ((state_q == ST_RAMP || state_q == ST_RUN) && trip_c) begin
      state_d  = ST_COOL;
      active_d = '0;
      tmr_d    = '0;
      if (trip_q != '1) trip_d = trip_q + 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          active_d = '0;
          if (banks_c != 4'd0) begin
            state_d = ST_RAMP;
            tmr_d   = '0;
          end
        end
        ST_RAMP: begin
          if (banks_c <= active_q) begin
            active_d = banks_c;
            tmr_d    = '0;
            state_d  = (banks_c == 4'd0) ? ST_IDLE : ST_RUN;
          end else if (tmr_q == TMR_LAST) begin
            active_d = active_q + 4'd1;
            tmr_d    = '0;
            if (active_q + 4'd1 == banks_c) state_d = ST_RUN;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (banks_c == 4'd0) begin
            state_d  = ST_IDLE;
            active_d = '0;
          end else if (banks_c < active_q) begin
            active_d = banks_c;
          end else if (banks_c > active_q) begin
            state_d = ST_RAMP;
            tmr_d   = '0;
          end
        end
        ST_COOL: begin
          active_d = '0;
          if (rearm_c) begin
            state_d = ST_RAMP;
            tmr_d   = '0;
          end
        end
      endcase
    end
  end

  // Gate enables follow the admitted count from the previous cycle, chopped by PWM.
  always_comb begin
    bank_en_d = '0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      bank_en_d[k] = (4'(k) < active_q) && pwm_on_c && (state_q != ST_COOL);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      active_q  <= '0;
      tmr_q     <= '0;
      trip_q    <= '0;
      on_q      <= '0;
      pwm_q     <= '0;
      bank_en_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      tmr_q     <= tmr_d;
      trip_q    <= trip_d;
      pwm_q     <= pwm_q + 1'b1;
      bank_en_q <= bank_en_d;
      if ((|bank_en_q) && (on_q != '1)) on_q <= on_q + 1'b1;
    end
  end

  assign bus.bank_en      = bank_en_q;
  assign bus.state        = 2'(state_q);
  assign bus.active_count = active_q;
  assign bus.on_cycles    = on_q;
  assign bus.trip_count   = trip_q;

endmodule

// File: tb/tb_heater_bank_sched.sv
// Directed bench for heater_bank_sched: ramp timing, PWM duty, trip/re-arm hysteresis,
// bank clamping, priority, mid-ramp reset, and counter saturation on a narrow-counter build.
module tb_heater_bank_sched;

  logic Clk = 1'b0;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 Clk = ~Clk;

  heater_bank_sched_if #(.NUM_BANKS(8), .PWM_BITS(8), .TEMP_BITS(12), .ON_BITS(32), .TRIP_BITS(16)) bi ();
  heater_bank_sched_if #(.NUM_BANKS(2), .PWM_BITS(2), .TEMP_BITS(4),  .ON_BITS(5),  .TRIP_BITS(4))  si ();

  heater_bank_sched #(
    .NUM_BANKS(8), .PWM_BITS(8), .RAMP_CYCLES(4), .TEMP_BITS(12), .ON_BITS(32), .TRIP_BITS(16)
  ) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bi)
  );

  heater_bank_sched #(
    .NUM_BANKS(2), .PWM_BITS(2), .RAMP_CYCLES(1), .TEMP_BITS(4), .ON_BITS(5), .TRIP_BITS(4)
  ) u_small (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (si)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          cnt;
  int          bad;
  logic [31:0] on0;

  initial begin
    Reset          = 1'b1;
    bi.cfg_enable  = 1'b0;
    bi.cfg_banks   = 4'd0;
    bi.cfg_duty    = 8'hFF;
    bi.cfg_temp_hi = 12'hFFF;
    bi.cfg_temp_lo = 12'h000;
    bi.temp_code   = 12'h000;
    bi.temp_valid  = 1'b0;
    si.cfg_enable  = 1'b0;
    si.cfg_banks   = 4'd0;
    si.cfg_duty    = 2'b11;
    si.cfg_temp_hi = 4'd4;
    si.cfg_temp_lo = 4'd4;
    si.temp_code   = 4'd4;
    si.temp_valid  = 1'b0;
    tick(3);
    chk("rst_state",  32'(bi.state),        32'd0);
    chk("rst_active", 32'(bi.active_count), 32'd0);
    chk("rst_bank",   32'(bi.bank_en),      32'h00);
    chk("rst_on",     bi.on_cycles,         32'd0);
    chk("rst_trip",   32'(bi.trip_count),   32'd0);

    // Soft-start ramp to 3 banks, one bank every 4 cycles
    Reset         = 1'b0;
    bi.cfg_enable = 1'b1;
    bi.cfg_banks  = 4'd3;
    si.cfg_enable = 1'b1;
    si.cfg_banks  = 4'd1;
    si.temp_valid = 1'b1;
    tick(1);
    chk("ramp_entry_state", 32'(bi.state),        32'd1);
    chk("ramp_entry_act",   32'(bi.active_count), 32'd0);
    tick(3);
    chk("ramp_c3_act",      32'(bi.active_count), 32'd0);
    tick(1);
    chk("ramp_c4_act",      32'(bi.active_count), 32'd1);
    chk("ramp_c4_bank",     32'(bi.bank_en),      32'h00);
    tick(1);
    chk("ramp_c5_bank",     32'(bi.bank_en),      32'h01);
    tick(3);
    chk("ramp_c8_act",      32'(bi.active_count), 32'd2);
    tick(4);
    chk("ramp_c12_act",     32'(bi.active_count), 32'd3);
    chk("ramp_c12_state",   32'(bi.state),        32'd2);
    chk("ramp_c12_bank",    32'(bi.bank_en),      32'h03);
    tick(1);
    chk("run_bank",         32'(bi.bank_en),      32'h07);
    chk("run_on_cycles",    bi.on_cycles,         32'd8);

    // PWM at 64/256
    bi.cfg_duty = 8'd64;
    tick(2);
    cnt = 0;
    bad = 0;
    on0 = bi.on_cycles;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      if (bi.bank_en[0]) cnt++;
      if (bi.bank_en != {5'b00000, {3{bi.bank_en[0]}}}) bad++;
    end
    chk("pwm64_high",  32'(cnt),             32'd64);
    chk("pwm64_on",    bi.on_cycles - on0,   32'd64);
    chk("pwm64_shape", 32'(bad),             32'd0);

    // Zero duty keeps every bank off
    bi.cfg_duty = 8'd0;
    tick(2);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      if (bi.bank_en != 8'h00) cnt++;
    end
    chk("pwm0_high", 32'(cnt), 32'd0);
    bi.cfg_duty = 8'hFF;
    tick(2);
    chk("pwm_full_bank", 32'(bi.bank_en), 32'h07);

    // Over-temp trip at exactly the threshold, then hysteresis
    bi.cfg_temp_hi = 12'h900;
    bi.cfg_temp_lo = 12'h800;
    bi.temp_code   = 12'h900;
    bi.temp_valid  = 1'b1;
    tick(1);
    chk("trip_state",  32'(bi.state),        32'd3);
    chk("trip_active", 32'(bi.active_count), 32'd0);
    chk("trip_count1", 32'(bi.trip_count),   32'd1);
    bi.temp_code = 12'h850;
    tick(1);
    chk("cool_bank",    32'(bi.bank_en), 32'h00);
    chk("cool_850",     32'(bi.state),   32'd3);
    bi.temp_code  = 12'h000;
    bi.temp_valid = 1'b0;
    tick(1);
    chk("cool_invalid", 32'(bi.state),   32'd3);
    bi.temp_code  = 12'h800;
    bi.temp_valid = 1'b1;
    tick(1);
    chk("rearm_state",  32'(bi.state),        32'd1);
    chk("rearm_active", 32'(bi.active_count), 32'd0);
    bi.temp_valid = 1'b0;

    // Target drops below admitted count mid-ramp
    bi.cfg_banks = 4'd5;
    tick(8);
    chk("drop_pre_act",   32'(bi.active_count), 32'd2);
    chk("drop_pre_state", 32'(bi.state),        32'd1);
    bi.cfg_banks = 4'd1;
    tick(1);
    chk("drop_act",   32'(bi.active_count), 32'd1);
    chk("drop_state", 32'(bi.state),        32'd2);
    tick(1);
    chk("drop_bank",  32'(bi.bank_en),      32'h01);

    // Request above NUM_BANKS clamps to 8
    bi.cfg_banks = 4'd12;
    tick(1);
    chk("clamp_ramp_state", 32'(bi.state),        32'd1);
    chk("clamp_ramp_act",   32'(bi.active_count), 32'd1);
    tick(27);
    chk("clamp_pre_act",    32'(bi.active_count), 32'd7);
    tick(1);
    chk("clamp_act",        32'(bi.active_count), 32'd8);
    chk("clamp_state",      32'(bi.state),        32'd2);
    tick(5);
    chk("clamp_hold_act",   32'(bi.active_count), 32'd8);
    chk("clamp_bank",       32'(bi.bank_en),      32'hFF);
    bi.cfg_banks = 4'd6;
    tick(1);
    chk("run_dec_act",      32'(bi.active_count), 32'd6);
    chk("run_dec_state",    32'(bi.state),        32'd2);

    // Disable wins over a simultaneous over-temp sample
    bi.cfg_enable = 1'b0;
    bi.temp_code  = 12'hA00;
    bi.temp_valid = 1'b1;
    tick(1);
    chk("prio_state", 32'(bi.state),        32'd0);
    chk("prio_act",   32'(bi.active_count), 32'd0);
    chk("prio_trip",  32'(bi.trip_count),   32'd1);
    bi.temp_valid = 1'b0;

    // Reset asserted mid-ramp
    bi.cfg_enable = 1'b1;
    bi.cfg_banks  = 4'd3;
    tick(1);
    tick(6);
    chk("rramp_pre_act", 32'(bi.active_count), 32'd1);
    Reset = 1'b1;
    tick(1);
    chk("rramp_state",  32'(bi.state),        32'd0);
    chk("rramp_active", 32'(bi.active_count), 32'd0);
    chk("rramp_bank",   32'(bi.bank_en),      32'h00);
    chk("rramp_on",     bi.on_cycles,         32'd0);
    chk("rramp_trip",   32'(bi.trip_count),   32'd0);
    Reset         = 1'b0;
    bi.cfg_enable = 1'b0;

    // Narrow build: trip every other cycle with hi == lo, then saturate counters
    si.temp_code  = 4'd4;
    si.temp_valid = 1'b1;
    tick(28);
    chk("sm_trip14",      32'(si.trip_count), 32'd14);
    tick(4);
    chk("sm_trip_sat",    32'(si.trip_count), 32'd15);
    tick(10);
    chk("sm_trip_hold",   32'(si.trip_count), 32'd15);
    chk("sm_state_cool",  32'(si.state),      32'd3);
    si.temp_code = 4'd0;
    tick(18);
    chk("sm_on15",        32'(si.on_cycles),  32'd15);
    tick(30);
    chk("sm_on_sat",      32'(si.on_cycles),  32'd31);
    chk("sm_trip_final",  32'(si.trip_count), 32'd15);
    chk("sm_bank",        32'(si.bank_en),    32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
